// File: rtl/exp_avg_pkg.sv
// exp_avg_pkg: shared types and width helpers for the multi-channel exponential averager.
package exp_avg_pkg;
    typedef enum logic [1:0] {RUN, DRAIN, CLEAR} state_t;
    typedef struct packed {
        logic valid;
        logic primed;
    } stage_t;
    function automatic int acc_w(input int data_w, input int frac_w);
        return data_w + frac_w;
    endfunction
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/exp_avg_datapath.sv
// exp_avg_datapath: one-sample prime/diff/shift/add/floor step of the exponential average.
module exp_avg_datapath #(
    parameter int DATA_W = 16,
    parameter int FRAC_W = 4,
    parameter int KW     = 4
) (
    input  logic signed [DATA_W-1:0]        x,
    input  logic signed [DATA_W+FRAC_W-1:0] acc,
    input  logic                            primed,
    input  logic        [KW-1:0]            k,
    output logic signed [DATA_W+FRAC_W-1:0] acc_new,
    output logic signed [DATA_W-1:0]        y
);
    localparam int AW = DATA_W + FRAC_W;
    logic signed [AW-1:0] x_ext;
    logic signed [AW:0]   diff, step;
    assign x_ext = AW'(x) <<< FRAC_W;
    assign diff  = (AW+1)'(x_ext) - (AW+1)'(acc);
    assign step  = diff >>> k;
    // The result lies between acc and x_ext, so truncating back to AW bits is exact.
    assign acc_new = primed ? acc + step[AW-1:0] : x_ext;
    assign y       = acc_new[AW-1:FRAC_W];
endmodule

// File: rtl/exp_averager_mc.sv
// exp_averager_mc: time-multiplexed per-channel exponential averager, 2-stage pipeline with clear sweep.
module exp_averager_mc
    import exp_avg_pkg::*;
#(
    parameter int DATA_W    = 16,
    parameter int CHANNELS  = 4,
    parameter int FRAC_W    = 4,
    parameter int SHIFT_MAX = 8
) (
    input  logic                                clk,
    input  logic                                reset_n,
    input  logic                                in_valid,
    output logic                                in_ready,
    input  logic [idx_w(CHANNELS)-1:0]          in_channel,
    input  logic signed [DATA_W-1:0]            in_data,
    input  logic                                cfg_we,
    input  logic [idx_w(CHANNELS)-1:0]          cfg_channel,
    input  logic [idx_w(SHIFT_MAX+1)-1:0]       cfg_shift,
    input  logic                                clear_all,
    output logic                                out_valid,
    output logic [idx_w(CHANNELS)-1:0]          out_channel,
    output logic signed [DATA_W-1:0]            out_data
);
    localparam int AW = acc_w(DATA_W, FRAC_W);
    localparam int CW = idx_w(CHANNELS);
    localparam int KW = idx_w(SHIFT_MAX + 1);

    state_t               state, state_nx;
    logic [CW-1:0]        clr_idx;
    logic                 clr_last, accept, fwd;
    logic signed [AW-1:0] acc_mem [CHANNELS];
    logic [CHANNELS-1:0]  primed_mem;
    logic [KW-1:0]        shift_mem [CHANNELS];
    logic [KW-1:0]        k_in;
    stage_t               s1;
    logic [CW-1:0]        s1_ch;
    logic signed [DATA_W-1:0] s1_x, dp_y;
    logic signed [AW-1:0] s1_acc, dp_acc;
    logic [KW-1:0]        s1_k;

    assign in_ready = (state == RUN);
    assign accept   = in_valid && in_ready;
    assign clr_last = (clr_idx == CW'(CHANNELS - 1));
    assign k_in     = (int'(cfg_shift) > SHIFT_MAX) ? KW'(SHIFT_MAX) : cfg_shift;
    // Stage 2 writes this channel on the same edge, so take its fresh result instead of the array.
    assign fwd      = s1.valid && (s1_ch == in_channel);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= RUN;
            clr_idx <= '0;
        end else begin
            state   <= state_nx;
            clr_idx <= (state == CLEAR) ? clr_idx + CW'(1) : '0;
        end
    end

    always_comb begin
        state_nx = state;
        state_nx = (state == RUN)   ? (clear_all ? DRAIN : RUN) :
                   (state == DRAIN) ? CLEAR :
                   (clr_last ? RUN : CLEAR);
    end

    exp_avg_datapath #(.DATA_W(DATA_W), .FRAC_W(FRAC_W), .KW(KW)) u_dp (
        .x(s1_x), .acc(s1_acc), .primed(s1.primed), .k(s1_k), .acc_new(dp_acc), .y(dp_y)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1          <= '0;
            s1_ch       <= '0;
            s1_x        <= '0;
            s1_acc      <= '0;
            s1_k        <= '0;
            out_valid   <= 1'b0;
            out_channel <= '0;
            out_data    <= '0;
            primed_mem  <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                acc_mem[i]   <= '0;
                shift_mem[i] <= '0;
            end
        end else begin
            s1.valid  <= accept;
            out_valid <= s1.valid;
            if (accept) begin
                s1_ch     <= in_channel;
                s1_x      <= in_data;
                s1_acc    <= fwd ? dp_acc : acc_mem[in_channel];
                s1.primed <= fwd || primed_mem[in_channel];
                s1_k      <= shift_mem[in_channel];
            end
            if (s1.valid) begin
                out_data            <= dp_y;
                out_channel         <= s1_ch;
                acc_mem[s1_ch]      <= dp_acc;
                primed_mem[s1_ch]   <= 1'b1;
            end
            if (state == CLEAR) begin
                acc_mem[clr_idx]    <= '0;
                primed_mem[clr_idx] <= 1'b0;
            end
            if (cfg_we)
                shift_mem[cfg_channel] <= k_in;
        end
    end
endmodule

// File: tb/tb_exp_averager_mc.sv
// tb_exp_averager_mc: directed and random checks of exp_averager_mc against an arithmetic reference model.
module tb_exp_averager_mc;
    localparam int SC = 16;
    localparam int NCH = 4;

    logic clk = 1'b0;
    logic reset_n = 1'b1;
    logic in_valid = 1'b0, cfg_we = 1'b0, clear_all = 1'b0;
    logic [1:0] in_channel = '0, cfg_channel = '0;
    logic signed [15:0] in_data = '0;
    logic [3:0] cfg_shift = '0;
    logic in_ready, out_valid;
    logic [1:0] out_channel;
    logic signed [15:0] out_data;

    exp_averager_mc dut (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_channel(in_channel), .in_data(in_data), .cfg_we(cfg_we), .cfg_channel(cfg_channel),
        .cfg_shift(cfg_shift), .clear_all(clear_all), .out_valid(out_valid),
        .out_channel(out_channel), .out_data(out_data)
    );

    always #5 clk = ~clk;

    typedef struct {int ch; int data; int due;} exp_t;
    exp_t q[$];
    int ra[NCH], rk[NCH];
    bit rp[NCH];
    int busy = 0, ncnt = 0, n_assert = 0, n_fail = 0;

    function automatic int fdiv(input int a, input int d);
        int r = a / d;
        if ((a % d) != 0 && a < 0) r = r - 1;
        return r;
    endfunction

    function automatic int rand16();
        int r = int'($urandom_range(0, 65535));
        return r - 32768;
    endfunction

    task automatic model_reset(input bit keep_k);
        for (int i = 0; i < NCH; i++) begin
            ra[i] = 0;
            rp[i] = 1'b0;
            if (!keep_k) rk[i] = 0;
        end
    endtask

    task automatic model(input int ch, input int x);
        if (!rp[ch]) begin
            ra[ch] = x * SC;
            rp[ch] = 1'b1;
        end else
            ra[ch] = ra[ch] + fdiv(x * SC - ra[ch], 1 << rk[ch]);
        q.push_back('{ch, fdiv(ra[ch], SC), ncnt + 2});
    endtask

    task automatic step(input bit v, input int ch, input int x, input bit we = 1'b0,
                        input int cch = 0, input int ck = 0, input bit clr = 1'b0);
        bit rdy;
        in_valid = v; in_channel = 2'(ch); in_data = 16'(x);
        cfg_we = we; cfg_channel = 2'(cch); cfg_shift = 4'(ck); clear_all = clr;
        rdy = (busy == 0);
        n_assert++;
        assert (in_ready === rdy) else begin
            n_fail++;
            $error("FAIL in_ready: got %b expected %b", in_ready, rdy);
        end
        @(posedge clk);
        #1;
        if (v && rdy) model(ch, x);
        if (we) rk[cch] = (ck > 8) ? 8 : ck;
        if (busy > 0) busy--;
        else if (clr) begin
            busy = NCH + 1;
            model_reset(1'b1);
        end
        in_valid = 1'b0; cfg_we = 1'b0; clear_all = 1'b0;
    endtask

    always @(negedge clk) begin
        ncnt++;
        if (reset_n) begin
            if (q.size() != 0 && q[0].due == ncnt) begin
                exp_t e;
                e = q.pop_front();
                n_assert++;
                assert (out_valid === 1'b1) else begin
                    n_fail++;
                    $error("FAIL out_valid: got %b expected 1 (ch %0d)", out_valid, e.ch);
                end
                n_assert++;
                assert (out_channel === 2'(e.ch)) else begin
                    n_fail++;
                    $error("FAIL out_channel: got %0d expected %0d", out_channel, e.ch);
                end
                n_assert++;
                assert (out_data === 16'(e.data)) else begin
                    n_fail++;
                    $error("FAIL out_data ch%0d: got %0d expected %0d", e.ch, out_data, e.data);
                end
            end else begin
                n_assert++;
                assert (out_valid === 1'b0) else begin
                    n_fail++;
                    $error("FAIL stray out_valid: got %b expected 0", out_valid);
                end
            end
        end
    end

    initial begin
        model_reset(1'b0);
        #2 reset_n = 1'b0;
        #1;
        n_assert++;
        assert ({out_valid, out_channel, out_data} === 19'd0) else begin
            n_fail++;
            $error("FAIL reset outputs: got %b/%0d/%0d expected 0/0/0", out_valid, out_channel, out_data);
        end
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        step(0, 0, 0);

        step(0, 0, 0, 1, 0, 2);
        step(1, 0, 1000);
        step(1, 0, 0);
        step(1, 0, 0);
        step(0, 0, 0, 1, 1, 1);
        step(1, 1, 100);
        step(1, 1, 200);
        step(1, 1, 200);
        step(0, 0, 0, 1, 2, 0);
        step(1, 2, -32768);
        step(1, 2, 32767);
        step(0, 0, 0, 1, 3, 15);
        step(1, 3, 0);
        step(1, 3, 256);
        step(1, 0, 500, 1, 0, 0);
        step(1, 0, -700);
        step(0, 0, 0, 1, 0, 3);
        step(0, 0, 0);

        for (int i = 0; i < 30; i++) step(1, i % 2, rand16());

        step(1, 1, 1234, 0, 0, 0, 1);
        for (int i = 0; i < 5; i++) step(1, 0, 999);
        step(1, 0, 42);
        step(1, 0, -42);
        step(1, 2, 77);
        step(0, 0, 0);

        for (int i = 0; i < 300; i++)
            step($urandom_range(0, 3) != 0, int'($urandom_range(0, 3)), rand16(),
                 $urandom_range(0, 7) == 0, int'($urandom_range(0, 3)),
                 int'($urandom_range(0, 15)), $urandom_range(0, 99) == 0);
        while (busy > 0) step(0, 0, 0);

        step(1, 0, 300);
        step(1, 1, -300);
        reset_n = 1'b0;
        #1;
        n_assert++;
        assert (out_valid === 1'b0) else begin
            n_fail++;
            $error("FAIL out_valid during reset: got %b expected 0", out_valid);
        end
        q.delete();
        model_reset(1'b0);
        busy = 0;
        @(posedge clk);
        #1 reset_n = 1'b1;
        step(0, 0, 0);
        step(1, 0, 5000);
        step(1, 1, -17);
        step(1, 0, 0);
        for (int i = 0; i < 6; i++) step(0, 0, 0);

        n_assert++;
        assert (q.size() == 0) else begin
            n_fail++;
            $error("FAIL pending outputs: got %0d expected 0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/exp_averager_mc.md
# exp_averager_mc

Parametrised, multi-channel successor to the single-channel exponential averager. Computes y[n] = y[n-1] + (x[n] - y[n-1]) * 2^-k independently for CHANNELS time-multiplexed channels, with a per-channel shift k, fractional guard bits, first-sample seeding and a clear sweep. It sits between a sample source (e.g. the sine generator feeding q_sine) and downstream consumers in the filter chain.

## Interface
- DATA_W, 16, signed sample width in/out
- CHANNELS, 4, number of independent channels (>=1)
- FRAC_W, 4, fractional guard bits kept in each accumulator
- SHIFT_MAX, 8, largest legal shift k; larger cfg values clamp to this
- clk  in  1  system clock, all state on rising edge
- reset_n  in  1  asynchronous, active-low reset
- in_valid  in  1  sample present
- in_ready  out  1  block accepts a sample this cycle
- in_channel  in  $clog2(CHANNELS) (min 1)  channel of the sample
- in_data  in  DATA_W signed  sample x
- cfg_we  in  1  write cfg_shift to channel cfg_channel
- cfg_channel  in  $clog2(CHANNELS)  target channel
- cfg_shift  in  $clog2(SHIFT_MAX+1)  new k
- clear_all  in  1  request: unprime and zero every channel
- out_valid  out  1  one-cycle pulse, result present
- out_channel  out  $clog2(CHANNELS)  channel of result
- out_data  out  DATA_W signed  filtered output y

## Operation
- Per channel: ACC_W = DATA_W+FRAC_W signed accumulator, primed flag, shift register (reset value 0).
- x_ext = in_data << FRAC_W. Unprimed channel: acc <= x_ext, primed <= 1, out = in_data exactly.
- Primed: diff = x_ext - acc (ACC_W+1 bits); acc <= acc + (diff >>> k) (arithmetic shift). Result always between old acc and x_ext, so no overflow, no saturation logic.
- out_data = acc_new >>> FRAC_W (floor, toward -inf). k = 0 is pass-through.
- cfg write takes effect for samples accepted on later edges; a sample accepted on the same edge uses the old k. k values above SHIFT_MAX are stored as SHIFT_MAX.
- FSM states RUN, DRAIN, CLEAR. in_ready = 1 only in RUN (registered, no combinational path from inputs).
- RUN: clear_all high at an edge -> DRAIN; a sample accepted on that same edge completes normally.
- DRAIN: 1 cycle, lets stage 2 write back.
- CLEAR: CHANNELS cycles, index 0..CHANNELS-1, writes acc=0, primed=0 (shift registers keep their values) -> RUN.
- clear_all ignored outside RUN. cfg writes accepted in every state.

## Timing
- 2-stage pipeline. Sample accepted at edge N: stage 1 registers x, channel, acc, primed, k; stage 2 computes, writes back and registers outputs at edge N+1; out_valid high in the cycle after edge N+1 (latency 2). Throughput 1 sample/cycle, any channel order.
- Hazard: if stage 1 reads the channel stage 2 writes on the same edge, forward the new acc and primed=1. Back-to-back samples on one channel must match the unpipelined result.
- No backpressure on the output; out_valid pulses for exactly one cycle per accepted sample.
- Reset (asynchronous, immediate): out_valid=0, out_data=0, out_channel=0, all acc=0, primed=0, shifts=0, pipeline empty, FSM=RUN; in_ready=1 from the first edge after release. A reset mid-pipeline drops the in-flight samples without output.

## Structure
- Package exp_avg_pkg: state enum (RUN, DRAIN, CLEAR), ACC_W/index-width helper functions, pipeline stage struct type.
- Sub-module exp_avg_datapath: combinational prime/diff/shift/add/floor for one sample. The top level holds the FSM, channel state arrays, forwarding and pipeline registers.

## Test plan
- Defaults, ch0 k=2; samples 1000, 0, 0 -> outputs 1000, 750, 562 on ch0, each 2 cycles after acceptance.
- ch1 k=1; 100, 200, 200 on consecutive cycles -> 100, 150, 175 (forwarding check).
- ch2 k=0; -32768 then 32767 -> -32768, 32767. cfg_shift=15 on ch3, then 0, 256 -> 0, 1 (k clamped to 8: 4096>>>8=16 -> 1).
- Interleave ch0/ch1 each cycle with distinct streams -> each matches the per-channel reference model; no cross-talk.
- clear_all with a sample in flight -> that output still emitted; in_ready low 5 cycles; next ch0 sample 42 -> output 42 (reprimed), shifts retained.
- reset_n low mid-stream -> out_valid 0 immediately; after release the first sample reprimes and no stale outputs appear.
